// File: rtl/udm_cordic_csr.sv
// Bus-attached iterative CORDIC sine/cosine peripheral for the udm debug bus.
// Rotation mode, 18-bit signed datapath, Q2.14 results with saturating write-back.
module udm_cordic_csr #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          ITERATIONS = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        done_o
);
  localparam int                 IW      = 5;
  localparam logic signed [15:0] ANG_MAX = 16'sd25736;
  localparam logic signed [17:0] X_INIT  = 18'sd9949;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic signed [17:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [IW-1:0]      it_q, it_d;
  logic signed [15:0] ang_q, ang_d, cos_q, cos_d, sin_q, sin_d;
  logic [31:0]        cyc_q, cyc_d;
  logic               done_q, done_d, sat_q, sat_d, pulse_q, pulse_d;
  logic               resp_q;
  logic [31:0]        rdata_q, rd_mux;

  logic [31:0] off;
  logic [2:0]  idx;
  logic        hit, wr_en, rd_en, start;
  logic        unused_bits;

  assign off       = bus_addr_bi - BASE_ADDR;
  assign hit       = (bus_addr_bi >= BASE_ADDR) && (off < 32'h14);
  assign idx       = off[4:2];
  assign bus_ack_o = bus_req_i & hit;
  assign wr_en     = bus_ack_o & bus_we_i;
  assign rd_en     = bus_ack_o & ~bus_we_i;
  assign start     = wr_en && (idx == 3'd0) && bus_wdata_bi[0] && (state_q == S_IDLE);
  assign unused_bits = ^{off[31:5], off[1:0], bus_be_bi[3:2], bus_wdata_bi[31:16]};

  function automatic logic signed [17:0] atan_rom(input logic [IW-1:0] i);
    case (i)
      5'd0:    return 18'sd12868;
      5'd1:    return 18'sd7596;
      5'd2:    return 18'sd4014;
      5'd3:    return 18'sd2037;
      5'd4:    return 18'sd1023;
      5'd5:    return 18'sd512;
      5'd6:    return 18'sd256;
      5'd7:    return 18'sd128;
      5'd8:    return 18'sd64;
      5'd9:    return 18'sd32;
      5'd10:   return 18'sd16;
      5'd11:   return 18'sd8;
      5'd12:   return 18'sd4;
      5'd13:   return 18'sd2;
      5'd14:   return 18'sd1;
      default: return 18'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)  return 16'sh7FFF;
    if (v < -18'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  // One micro-rotation; direction chosen by the sign of the residual angle.
  logic               dir;
  logic signed [17:0] x_sh, y_sh, atan_v, x_nx, y_nx, z_nx;
  assign dir    = ~z_q[17];
  assign x_sh   = x_q >>> it_q;
  assign y_sh   = y_q >>> it_q;
  assign atan_v = atan_rom(it_q);
  assign x_nx   = dir ? x_q - y_sh   : x_q + y_sh;
  assign y_nx   = dir ? y_q + x_sh   : y_q - x_sh;
  assign z_nx   = dir ? z_q - atan_v : z_q + atan_v;

  logic signed [15:0] ang_clip;
  logic               ang_ovr;
  always_comb begin
    ang_clip = ang_q;
    ang_ovr  = 1'b0;
    if (ang_q > ANG_MAX) begin
      ang_clip = ANG_MAX;
      ang_ovr  = 1'b1;
    end else if (ang_q < -ANG_MAX) begin
      ang_clip = -ANG_MAX;
      ang_ovr  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    it_d    = it_q;
    ang_d   = ang_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
    sat_d   = sat_q;
    pulse_d = 1'b0;
    if (wr_en && idx == 3'd1) begin
      if (bus_be_bi[0]) ang_d[7:0]  = bus_wdata_bi[7:0];
      if (bus_be_bi[1]) ang_d[15:8] = bus_wdata_bi[15:8];
    end
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        x_d     = X_INIT;
        y_d     = '0;
        z_d     = {{2{ang_clip[15]}}, ang_clip};
        it_d    = '0;
        sat_d   = ang_ovr;
        done_d  = 1'b0;
      end
      S_RUN: begin
        x_d  = x_nx;
        y_d  = y_nx;
        z_d  = z_nx;
        it_d = it_q + 1'b1;
        if (it_q == IW'(ITERATIONS - 1)) begin
          state_d = S_IDLE;
          cos_d   = sat16(x_nx);
          sin_d   = sat16(y_nx);
          done_d  = 1'b1;
          pulse_d = 1'b1;
          cyc_d   = cyc_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A clear landing on the completion cycle wins over the increment.
    if (wr_en && idx == 3'd4) cyc_d = '0;
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      3'd0:    rd_mux = {29'b0, sat_q, done_q, state_q == S_RUN};
      3'd1:    rd_mux = {{16{ang_q[15]}}, ang_q};
      3'd2:    rd_mux = {{16{cos_q[15]}}, cos_q};
      3'd3:    rd_mux = {{16{sin_q[15]}}, sin_q};
      3'd4:    rd_mux = cyc_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      it_q    <= '0;
      ang_q   <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      pulse_q <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      it_q    <= it_d;
      ang_q   <= ang_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      pulse_q <= pulse_d;
      resp_q  <= rd_en;
      rdata_q <= rd_en ? rd_mux : '0;
    end
  end

  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign done_o       = pulse_q;
endmodule

// File: tb/tb_udm_cordic_csr.sv
// Directed + randomized bench for udm_cordic_csr; results compared against real-valued cos/sin.
module tb_udm_cordic_csr;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          ITER = 16;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        ack, resp, done;
  logic [31:0] rdata;

  int n_assert = 0, n_fail = 0;
  int cyc_cnt = 0, pulse_cnt = 0, pulse_cyc = -1;
  int m_cycles = 0;
  logic m_sat = 1'b0;

  udm_cordic_csr #(.BASE_ADDR(BASE), .ITERATIONS(ITER)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus_req_i(req), .bus_we_i(we),
    .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
    .bus_ack_o(ack), .bus_resp_o(resp), .bus_rdata_bo(rdata), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (done) begin
    pulse_cnt <= pulse_cnt + 1;
    pulse_cyc <= cyc_cnt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
    n_assert++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Called and returning on a negedge; each access occupies exactly one request cycle.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, output int acc);
    acc = cyc_cnt;
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    #1 chk("wr_ack", 32'(ack), 32'd1);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a;
    #1 chk("rd_ack", 32'(ack), 32'd1);
    @(negedge clk);
    req = 1'b0;
    chk("rd_resp", 32'(resp), 32'd1);
    d = rdata;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_resp", 32'(resp), 32'd0);
    chk("idle_rdata", rdata, 32'd0);
  endtask

  task automatic wait_to(input int t);
    while (cyc_cnt < t) @(negedge clk);
  endtask

  task automatic start_run(input logic [15:0] ang, output int acc, output int p0);
    int dummy;
    wr(BASE + 32'h4, {16'h0, ang}, 4'hF, dummy);
    p0 = pulse_cnt;
    wr(BASE, 32'h1, 4'hF, acc);
  endtask

  task automatic finish_run(input string tag, input logic [15:0] ang, input int acc,
                            input int p0, input int tol, output int sin_raw);
    logic [31:0] d;
    int sa, ec, es;
    real th;
    rd(BASE, d);
    chk({tag, "_busy"}, {30'b0, d[1:0]}, 32'b01);
    for (int k = 0; k < 40; k++) begin
      rd(BASE, d);
      if (d[1]) break;
    end
    sa = int'($signed(ang));
    m_sat = 1'b0;
    if (sa > 25736)  begin sa = 25736;  m_sat = 1'b1; end
    if (sa < -25736) begin sa = -25736; m_sat = 1'b1; end
    m_cycles++;
    th = real'(sa) / 16384.0;
    ec = int'(16384.0 * $cos(th));
    es = int'(16384.0 * $sin(th));
    chk({tag, "_ctrl"}, d, {29'b0, m_sat, 2'b10});
    chk({tag, "_pulse_cyc"}, 32'(pulse_cyc), 32'(acc + ITER + 1));
    chk({tag, "_pulse_cnt"}, 32'(pulse_cnt), 32'(p0 + 1));
    rd(BASE + 32'h8, d);
    chk_near({tag, "_cos"}, int'($signed(d)), ec, tol);
    rd(BASE + 32'hC, d);
    chk_near({tag, "_sin"}, int'($signed(d)), es, tol);
    sin_raw = int'(d);
    rd(BASE + 32'h10, d);
    chk({tag, "_cycles"}, d, 32'(m_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [15:0] ra;
    int acc, p0, sr, dummy;

    repeat (3) @(negedge clk);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_done_o", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values, back-to-back reads.
    for (int r = 0; r < 5; r++) begin
      rd(BASE + 32'(4 * r), d);
      chk($sformatf("rst_reg%0d", r), d, 32'd0);
    end
    idle_chk();

    start_run(16'd0, acc, p0);
    finish_run("ang0", 16'd0, acc, p0, 4, sr);

    start_run(16'd8579, acc, p0);
    finish_run("pi6", 16'd8579, acc, p0, 4, sr);

    start_run(16'hDE7D, acc, p0);
    finish_run("neg_pi6", 16'hDE7D, acc, p0, 4, sr);
    chk("neg_sin_sext", {16'h0, 16'(sr >>> 16)}, 32'h0000FFFF);
    rd(BASE + 32'h4, d);
    chk("angle_sext", d, 32'hFFFFDE7D);

    start_run(16'd30000, acc, p0);
    finish_run("sat", 16'd30000, acc, p0, 4, sr);
    start_run(16'd0, acc, p0);
    finish_run("unsat", 16'd0, acc, p0, 4, sr);

    // Start bit clear: no run, flags untouched.
    wr(BASE, 32'h0, 4'hF, dummy);
    rd(BASE, d);
    chk("nostart_ctrl", d, 32'b010);

    // Start while busy is ignored; ANGLE write mid-run only updates the register.
    start_run(16'd8579, acc, p0);
    wait_to(acc + 5);
    wr(BASE + 32'h4, 32'd1000, 4'hF, dummy);
    wr(BASE, 32'h1, 4'hF, dummy);
    finish_run("busy_restart", 16'd8579, acc, p0, 4, sr);
    rd(BASE + 32'h4, d);
    chk("busy_angle", d, 32'd1000);
    repeat (25) @(negedge clk);
    chk("busy_no_second", 32'(pulse_cnt), 32'(p0 + 1));

    // Byte enables on ANGLE.
    wr(BASE + 32'h4, 32'h1234, 4'hF, dummy);
    wr(BASE + 32'h4, 32'hABCD, 4'b0010, dummy);
    rd(BASE + 32'h4, d);
    chk("angle_be", d, 32'hFFFFAB34);

    // CYCLES clear.
    wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, dummy);
    m_cycles = 0;
    rd(BASE + 32'h10, d);
    chk("cycles_clr", d, 32'd0);

    // Random angles: even steps in range, odd steps anywhere in 16 bits.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) ra = 16'($urandom_range(0, 51472) - 25736);
      else            ra = 16'($urandom);
      start_run(ra, acc, p0);
      finish_run($sformatf("rand%0d", k), ra, acc, p0, 6, sr);
    end

    // Reset mid-run with a read response in flight.
    start_run(16'd8579, acc, p0);
    wait_to(acc + 7);
    rd(BASE, d);
    rst_n = 1'b0;
    #1;
    chk("arst_resp", 32'(resp), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_done_o", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(BASE, d);
    chk("post_rst_ctrl", d, 32'd0);
    rd(BASE + 32'h8, d);
    chk("post_rst_cos", d, 32'd0);
    rd(BASE + 32'hC, d);
    chk("post_rst_sin", d, 32'd0);
    rd(BASE + 32'h10, d);
    chk("post_rst_cycles", d, 32'd0);
    repeat (25) @(negedge clk);
    chk("post_rst_no_pulse", 32'(pulse_cnt), 32'(p0));

    // Outside the window: no ack, no response.
    req = 1'b1; we = 1'b0; addr = BASE + 32'h20;
    #1 chk("oow_ack", 32'(ack), 32'd0);
    @(negedge clk);
    req = 1'b0;
    chk("oow_resp", 32'(resp), 32'd0);
    req = 1'b1; addr = BASE - 32'h4;
    #1 chk("below_ack", 32'(ack), 32'd0);
    @(negedge clk);
    req = 1'b0;
    chk("below_resp", 32'(resp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
